// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID-stage decoder and ID/EX control register for a 5-stage
// RV32I(M) pipeline. Handles load-use interlock, multi-cycle MDU occupancy
// of EX, branch flush and illegal-instruction marking.
module pipe_ctrl #(
   parameter int MDU_EN   = 1,
   parameter int MDU_LAT  = 4,
   parameter int LU_STALL = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] id_instr,
   input  logic        id_valid,
   input  logic        ex_flush,
   output logic        id_stall,
   output logic        mdu_busy,
   output logic        ex_valid,
   output logic        ex_RegWrite,
   output logic        ex_MemWrite,
   output logic        ex_MemRead,
   output logic        ex_ALUSrc,
   output logic [5:0]  ex_EXTOp,
   output logic [4:0]  ex_ALUOp,
   output logic [2:0]  ex_NPCOp,
   output logic [1:0]  ex_WDSel,
   output logic [2:0]  ex_DMType,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic        ex_mdu,
   output logic [2:0]  ex_mduop,
   output logic        ex_illegal
);

   // Everything that travels from ID into the EX stage register
   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic       memWrite;
      logic       memRead;
      logic       aluSrc;
      logic [5:0] extOp;
      logic [4:0] aluOp;
      logic [2:0] npcOp;
      logic [1:0] wdSel;
      logic [2:0] dmType;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       mdu;
      logic [2:0] mduOp;
      logic       illegal;
   } exCtrl_t;

   localparam logic [3:0] LatInit = 4'(MDU_LAT - 1);

   localparam logic [5:0] ExtShamt = 6'b100000;
   localparam logic [5:0] ExtI     = 6'b010000;
   localparam logic [5:0] ExtS     = 6'b001000;
   localparam logic [5:0] ExtB     = 6'b000100;
   localparam logic [5:0] ExtU     = 6'b000010;
   localparam logic [5:0] ExtJ     = 6'b000001;

   localparam logic [4:0] AluLui   = 5'b00001;
   localparam logic [4:0] AluAuipc = 5'b00010;
   localparam logic [4:0] AluAdd   = 5'b00011;
   localparam logic [4:0] AluSub   = 5'b00100;
   localparam logic [4:0] AluBne   = 5'b00101;
   localparam logic [4:0] AluBlt   = 5'b00110;
   localparam logic [4:0] AluBge   = 5'b00111;
   localparam logic [4:0] AluBltu  = 5'b01000;
   localparam logic [4:0] AluBgeu  = 5'b01001;
   localparam logic [4:0] AluSlt   = 5'b01010;
   localparam logic [4:0] AluSltu  = 5'b01011;
   localparam logic [4:0] AluXor   = 5'b01100;
   localparam logic [4:0] AluOr    = 5'b01101;
   localparam logic [4:0] AluAnd   = 5'b01110;
   localparam logic [4:0] AluSll   = 5'b01111;
   localparam logic [4:0] AluSrl   = 5'b10000;
   localparam logic [4:0] AluSra   = 5'b10001;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   exCtrl_t    w_dec;
   logic       w_rs1Used;
   logic       w_rs2Used;
   logic       w_hasRd;
   logic       w_illegal;
   logic       w_mduBusy;
   logic       w_loadUse;

   exCtrl_t    r_ex;
   logic [3:0] r_mduCnt;

   assign w_opcode = id_instr[6:0];
   assign w_funct3 = id_instr[14:12];
   assign w_funct7 = id_instr[31:25];

   // Combinational decode of the ID instruction into EX control fields
   always_comb begin
      w_dec     = '0;
      w_rs1Used = 1'b0;
      w_rs2Used = 1'b0;
      w_hasRd   = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         7'b0110011: begin
            w_hasRd   = 1'b1;
            w_rs1Used = 1'b1;
            w_rs2Used = 1'b1;
            if (w_funct7 == 7'b0000001) begin
               if (MDU_EN != 0) begin
                  w_dec.mdu   = 1'b1;
                  w_dec.mduOp = w_funct3;
               end else begin
                  w_illegal = 1'b1;
               end
            end else if (w_funct7 == 7'b0000000) begin
               case (w_funct3)
                  3'b000:  w_dec.aluOp = AluAdd;
                  3'b001:  w_dec.aluOp = AluSll;
                  3'b010:  w_dec.aluOp = AluSlt;
                  3'b011:  w_dec.aluOp = AluSltu;
                  3'b100:  w_dec.aluOp = AluXor;
                  3'b101:  w_dec.aluOp = AluSrl;
                  3'b110:  w_dec.aluOp = AluOr;
                  default: w_dec.aluOp = AluAnd;
               endcase
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
               w_dec.aluOp = AluSub;
            end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
               w_dec.aluOp = AluSra;
            end else begin
               w_illegal = 1'b1;
            end
         end
         7'b0010011: begin
            w_hasRd      = 1'b1;
            w_rs1Used    = 1'b1;
            w_dec.aluSrc = 1'b1;
            w_dec.extOp  = ExtI;
            case (w_funct3)
               3'b000: w_dec.aluOp = AluAdd;
               3'b010: w_dec.aluOp = AluSlt;
               3'b011: w_dec.aluOp = AluSltu;
               3'b100: w_dec.aluOp = AluXor;
               3'b110: w_dec.aluOp = AluOr;
               3'b111: w_dec.aluOp = AluAnd;
               3'b001: begin
                  w_dec.extOp = ExtShamt;
                  w_dec.aluOp = AluSll;
                  w_illegal   = (w_funct7 != 7'b0000000);
               end
               default: begin
                  w_dec.extOp = ExtShamt;
                  if (w_funct7 == 7'b0000000)
                     w_dec.aluOp = AluSrl;
                  else if (w_funct7 == 7'b0100000)
                     w_dec.aluOp = AluSra;
                  else
                     w_illegal = 1'b1;
               end
            endcase
         end
         7'b0000011: begin
            w_hasRd       = 1'b1;
            w_rs1Used     = 1'b1;
            w_dec.aluSrc  = 1'b1;
            w_dec.extOp   = ExtI;
            w_dec.aluOp   = AluAdd;
            w_dec.memRead = 1'b1;
            w_dec.wdSel   = 2'b01;
            case (w_funct3)
               3'b000:  w_dec.dmType = 3'b011;
               3'b001:  w_dec.dmType = 3'b001;
               3'b010:  w_dec.dmType = 3'b000;
               3'b100:  w_dec.dmType = 3'b100;
               3'b101:  w_dec.dmType = 3'b010;
               default: w_illegal    = 1'b1;
            endcase
         end
         7'b0100011: begin
            w_rs1Used      = 1'b1;
            w_rs2Used      = 1'b1;
            w_dec.aluSrc   = 1'b1;
            w_dec.extOp    = ExtS;
            w_dec.aluOp    = AluAdd;
            w_dec.memWrite = 1'b1;
            case (w_funct3)
               3'b000:  w_dec.dmType = 3'b011;
               3'b001:  w_dec.dmType = 3'b001;
               3'b010:  w_dec.dmType = 3'b000;
               default: w_illegal    = 1'b1;
            endcase
         end
         7'b1100011: begin
            w_rs1Used   = 1'b1;
            w_rs2Used   = 1'b1;
            w_dec.extOp = ExtB;
            w_dec.npcOp = 3'b001;
            case (w_funct3)
               3'b000:  w_dec.aluOp = AluSub;
               3'b001:  w_dec.aluOp = AluBne;
               3'b100:  w_dec.aluOp = AluBlt;
               3'b101:  w_dec.aluOp = AluBge;
               3'b110:  w_dec.aluOp = AluBltu;
               3'b111:  w_dec.aluOp = AluBgeu;
               default: w_illegal   = 1'b1;
            endcase
         end
         7'b1101111: begin
            w_hasRd     = 1'b1;
            w_dec.extOp = ExtJ;
            w_dec.aluOp = AluAdd;
            w_dec.npcOp = 3'b010;
            w_dec.wdSel = 2'b10;
         end
         7'b1100111: begin
            w_hasRd      = 1'b1;
            w_rs1Used    = 1'b1;
            w_dec.aluSrc = 1'b1;
            w_dec.extOp  = ExtI;
            w_dec.aluOp  = AluAdd;
            w_dec.npcOp  = 3'b100;
            w_dec.wdSel  = 2'b10;
            w_illegal    = (w_funct3 != 3'b000);
         end
         7'b0110111: begin
            w_hasRd      = 1'b1;
            w_dec.aluSrc = 1'b1;
            w_dec.extOp  = ExtU;
            w_dec.aluOp  = AluLui;
         end
         7'b0010111: begin
            w_hasRd      = 1'b1;
            w_dec.aluSrc = 1'b1;
            w_dec.extOp  = ExtU;
            w_dec.aluOp  = AluAuipc;
         end
         default: w_illegal = 1'b1;
      endcase

      if (w_illegal) begin
         w_dec         = '0;
         w_rs1Used     = 1'b0;
         w_rs2Used     = 1'b0;
         w_hasRd       = 1'b0;
         w_dec.illegal = 1'b1;
      end

      w_dec.valid    = 1'b1;
      w_dec.rd       = w_hasRd ? id_instr[11:7] : 5'd0;
      w_dec.regWrite = w_hasRd && (id_instr[11:7] != 5'd0);
      w_dec.rs1      = w_rs1Used ? id_instr[19:15] : 5'd0;
      w_dec.rs2      = w_rs2Used ? id_instr[24:20] : 5'd0;
   end

   assign w_mduBusy = (r_mduCnt != 4'd0);

   assign w_loadUse = (LU_STALL != 0) && r_ex.valid && r_ex.memRead &&
                      (r_ex.rd != 5'd0) &&
                      ((w_rs1Used && (r_ex.rd == id_instr[19:15])) ||
                       (w_rs2Used && (r_ex.rd == id_instr[24:20])));

   assign id_stall = !ex_flush && (w_mduBusy || w_loadUse);
   assign mdu_busy = w_mduBusy;

   // EX register and MDU occupancy counter: flush, then MDU hold, then bubbles, then capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ex     <= '0;
         r_mduCnt <= 4'd0;
      end else if (ex_flush) begin
         r_ex     <= '0;
         r_mduCnt <= 4'd0;
      end else if (w_mduBusy) begin
         r_mduCnt <= r_mduCnt - 4'd1;
      end else if (w_loadUse || !id_valid) begin
         r_ex     <= '0;
         r_mduCnt <= 4'd0;
      end else begin
         r_ex     <= w_dec;
         r_mduCnt <= w_dec.mdu ? LatInit : 4'd0;
      end
   end

   assign ex_valid    = r_ex.valid;
   assign ex_RegWrite = r_ex.regWrite;
   assign ex_MemWrite = r_ex.memWrite;
   assign ex_MemRead  = r_ex.memRead;
   assign ex_ALUSrc   = r_ex.aluSrc;
   assign ex_EXTOp    = r_ex.extOp;
   assign ex_ALUOp    = r_ex.aluOp;
   assign ex_NPCOp    = r_ex.npcOp;
   assign ex_WDSel    = r_ex.wdSel;
   assign ex_DMType   = r_ex.dmType;
   assign ex_rd       = r_ex.rd;
   assign ex_rs1      = r_ex.rs1;
   assign ex_rs2      = r_ex.rs2;
   assign ex_mdu      = r_ex.mdu;
   assign ex_mduop    = r_ex.mduOp;
   assign ex_illegal  = r_ex.illegal;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MDU_EN, default 1: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 flags those encodings illegal.
REQ-002 Parameter MDU_LAT, default 4, range 1..15: EX-stage occupancy in cycles of an RV32M instruction.
REQ-003 Parameter LU_STALL, default 1: 1 enables load-use interlock; 0 disables it (software-scheduled).
REQ-004 Clocking and reset: one clock, clk; reset rstn is asynchronous and active-low.
REQ-005 Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- id_instr  in  32  instruction in ID
- id_valid  in  1  id_instr valid
- ex_flush  in  1  taken branch/jump resolved in EX
- id_stall  out  1  hold PC and IF/ID
- mdu_busy  out  1  multi-cycle op occupying EX
- ex_valid  out  1  EX slot holds a real instruction
- ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc  out  1 each
- ex_EXTOp  out  6  one-hot extension type: SHAMT 100000, I 010000, S 001000, B 000100, U 000010, J 000001
- ex_ALUOp  out  5  team ALU encoding from ctrl_encode_def.v (ADD 00011, SUB 00100)
- ex_NPCOp  out  3  PLUS4 000, BRANCH 001, JUMP 010, JALR 100
- ex_WDSel  out  2  ALU 00, MEM 01, PC 10
- ex_DMType  out  3  word 000, half 001, byte 011, half-unsigned 010, byte-unsigned 100
- ex_rd, ex_rs1, ex_rs2  out  5 each  register indices
- ex_mdu  out  1  RV32M instruction
- ex_mduop  out  3  RV32M funct3
- ex_illegal  out  1  undecodable instruction

Function
REQ-006 ID decode SHALL be combinational over RV32I: R-type, I-ALU, shifts, loads, stores, branches, jal, jalr, lui, auipc; plus RV32M when MDU_EN=1.
REQ-007 Decoded values SHALL be captured into the EX register on each rising clk; all ex_* outputs SHALL be register outputs.
REQ-008 Source usage:
- rs1 used by R, I-ALU, load, store, branch, jalr.
- rs2 used by R, store, branch.
- ex_rs1/ex_rs2 SHALL be 0 when the source is unused.
REQ-009 ex_rd SHALL be 0 for store and branch; ex_RegWrite SHALL be 0 whenever ex_rd=0.
REQ-010 Bubble SHALL mean every ex_* output is 0, including ex_valid.
REQ-011 Load-use: with LU_STALL=1, ex_valid & ex_MemRead & ex_rd!=0 & ex_rd equal to a used ID source SHALL give id_stall=1 that cycle and load a bubble at the next edge.
REQ-012 MDU hold:
- An RV32M instruction entering EX SHALL load a counter with MDU_LAT-1.
- mdu_busy SHALL equal (counter!=0); the counter SHALL decrement by one per cycle while nonzero.
- While mdu_busy=1: id_stall=1 and the EX register SHALL hold its contents.
- MDU_LAT=1: mdu_busy SHALL never assert.
REQ-013 RV32M decode: ex_ALUOp=0, ex_RegWrite=1 (rd!=0), ex_WDSel=00, ex_ALUSrc=0.
REQ-014 id_valid=0 SHALL load a bubble.
REQ-015 Illegal instruction: ex_valid=1, ex_illegal=1, RegWrite/MemWrite/MemRead=0, ex_NPCOp=000.
REQ-016 Priority at each edge: ex_flush > MDU hold > load-use bubble > id_valid=0 bubble > normal capture.
REQ-017 ex_flush SHALL load a bubble and clear the MDU counter; id_stall SHALL be 0 in any cycle ex_flush=1.
REQ-018 id_stall SHALL be combinational from the EX register, counter and id_instr only.

Reset
REQ-019 rstn=0 SHALL immediately clear all ex_* outputs and the MDU counter; mdu_busy=0 and id_stall=0 during reset.
REQ-020 On reset release, the first rising clk SHALL capture normally.

Verification
REQ-021 id_instr=0x003100B3 (add x1,x2,x3), id_valid=1 -> next cycle ex_valid=1, ex_ALUOp=00011, ex_RegWrite=1, ex_rd=1, ex_rs1=2, ex_rs2=3, ex_EXTOp=0.
REQ-022 0x0000A283 (lw x5,0(x1)) then 0x00228333 (add x6,x5,x2) -> id_stall=1 for exactly one cycle, one bubble in EX, then add captured.
REQ-023 lw with rd=x0 followed by an instruction reading x0 -> id_stall stays 0.
REQ-024 0x022083B3 (mul x7,x1,x2), MDU_LAT=4 -> ex_mdu=1; mdu_busy=1 and id_stall=1 for 3 cycles; EX outputs constant for 4 cycles.
REQ-025 ex_flush=1 with valid add in ID -> next cycle ex_valid=0; rstn pulsed low mid mdu_busy -> all outputs 0 immediately.
REQ-026 MDU_EN=0 with 0x022083B3 -> ex_illegal=1, ex_RegWrite=0, mdu_busy=0.
